// File: rtl/sram_cache_controller_pkg.sv
// sram_cache_controller_pkg: shared constants, address field helpers and FSM state type
package sram_cache_controller_pkg;
  localparam int SETS = 64;
  localparam int IDX = $clog2(SETS);
  localparam int AW = 18;
  localparam int TAG_W = AW - IDX - 1;
  localparam int IDX_LSB = 1;
  localparam int TAG_LSB = IDX + 1;
  typedef enum logic [2:0] {IDLE, FILL0, GAP, FILL1, WRITE, DONE} state_t;
  function automatic logic [IDX-1:0] idx_of(input logic [AW-1:0] a);
    return a[TAG_LSB-1:IDX_LSB];
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [AW-1:0] a);
    return a[AW-1:TAG_LSB];
  endfunction
endpackage

// File: rtl/sram_cache_controller_cache_way_array.sv
// cache_way_array: two ways of {valid, tag, 64-bit line} plus per-set LRU, combinational lookup
module cache_way_array
  import sram_cache_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   idx_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             word_i,
  output logic             hit_o,
  output logic             hit_way_o,
  output logic [31:0]      hit_word_o,
  output logic             victim_o,
  input  logic             fill_i,
  input  logic [63:0]      fill_data_i,
  input  logic             wr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             lru_i
);
  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [63:0]      data_q [2][SETS];
  logic [1:0]       match;
  logic [63:0]      line;
  // lookup: hit detection, hit word select and victim choice (invalid way0, invalid way1, else LRU)
  always_comb begin
    match[0] = valid_q[0][idx_i] && (tag_q[0][idx_i] == tag_i);
    match[1] = valid_q[1][idx_i] && (tag_q[1][idx_i] == tag_i);
    hit_o = |match;
    hit_way_o = match[1];
    line = data_q[hit_way_o][idx_i];
    hit_word_o = word_i ? line[63:32] : line[31:0];
    victim_o = !valid_q[0][idx_i] ? 1'b0 : !valid_q[1][idx_i] ? 1'b1 : lru_q[idx_i];
  end
  // valid and LRU state: cleared on reset, set on fill, LRU points away from the last used way
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q <= '0;
    end else if (fill_i) begin
      valid_q[victim_o][idx_i] <= 1'b1;
      lru_q[idx_i] <= ~victim_o;
    end else if (lru_i && hit_o) begin
      lru_q[idx_i] <= ~hit_way_o;
    end
  end
  // tag and data storage: line fill into the victim, single-word update of the hit way
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[victim_o][idx_i] <= tag_i;
      data_q[victim_o][idx_i] <= fill_data_i;
    end else if (wr_i && hit_o) begin
      if (word_i) data_q[hit_way_o][idx_i][63:32] <= wr_data_i;
      else data_q[hit_way_o][idx_i][31:0] <= wr_data_i;
    end
  end
endmodule

// File: rtl/sram_cache_controller.sv
// sram_cache_controller: 2-way write-through read cache between MEM stage and SRAM controller
module sram_cache_controller
  import sram_cache_controller_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic [AW-1:0] sram_address,
  output logic [31:0]   sram_wdata,
  output logic          sram_re_en,
  output logic          sram_we_en,
  input  logic [31:0]   sram_rdata,
  input  logic          sram_ready
);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] sram_address_q, sram_address_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic [31:0]   word0_q, word0_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          re_q, re_d, we_q, we_d;
  logic [AW-1:0] la;
  logic          hit, hit_way, victim, fill, word_wr, lru_upd;
  logic [31:0]   hit_word;
  assign la = (state_q == IDLE) ? addr : addr_q;
  cache_way_array u_ways (
    .clk(clk),
    .rst(rst),
    .idx_i(idx_of(la)),
    .tag_i(tag_of(la)),
    .word_i(la[0]),
    .hit_o(hit),
    .hit_way_o(hit_way),
    .hit_word_o(hit_word),
    .victim_o(victim),
    .fill_i(fill),
    .fill_data_i({sram_rdata, word0_q}),
    .wr_i(word_wr),
    .wr_data_i(wdata),
    .lru_i(lru_upd)
  );
  // next state, SRAM request generation and cache update strobes
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    sram_address_d = sram_address_q;
    sram_wdata_d = sram_wdata_q;
    word0_d = word0_q;
    rdata_d = rdata_q;
    re_d = re_q;
    we_d = we_q;
    fill = 1'b0;
    word_wr = 1'b0;
    lru_upd = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WRITE;
          addr_d = addr;
          sram_address_d = addr;
          sram_wdata_d = wdata;
          we_d = 1'b1;
          word_wr = hit;
        end else if (rd_en && hit) begin
          lru_upd = 1'b1;
        end else if (rd_en) begin
          state_d = FILL0;
          addr_d = addr;
          sram_address_d = {addr[AW-1:1], 1'b0};
          re_d = 1'b1;
        end
      end
      FILL0: if (sram_ready && re_q) begin
        word0_d = sram_rdata;
        re_d = 1'b0;
        state_d = GAP;
      end
      GAP: begin
        sram_address_d = {addr_q[AW-1:1], 1'b1};
        re_d = 1'b1;
        state_d = FILL1;
      end
      FILL1: if (sram_ready && re_q) begin
        fill = 1'b1;
        re_d = 1'b0;
        rdata_d = addr_q[0] ? sram_rdata : word0_q;
        state_d = DONE;
      end
      WRITE: if (sram_ready && we_q) begin
        we_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and SRAM-side registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      sram_address_q <= '0;
      sram_wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      re_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      sram_address_q <= sram_address_d;
      sram_wdata_q <= sram_wdata_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
      re_q <= re_d;
      we_q <= we_d;
    end
  end
  assign ready = (state_q == DONE) || ((state_q == IDLE) && !wr_en && !(rd_en && !hit));
  assign rdata = (state_q == DONE) ? rdata_q : ((state_q == IDLE) && rd_en && !wr_en && hit) ? hit_word : 32'h0;
  assign sram_address = sram_address_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_re_en = re_q;
  assign sram_we_en = we_q;
endmodule

// File: tb/tb_sram_cache_controller.sv
// tb_sram_cache_controller: directed plus random checks against a behavioural cache and SRAM model
module tb_sram_cache_controller;
  logic clk = 0, rst, rd_en, wr_en, ready, sram_re_en, sram_we_en, sram_ready;
  logic [17:0] addr, sram_address;
  logic [31:0] wdata, rdata, sram_wdata, sram_rdata;
  int checks = 0, errors = 0;
  logic [31:0] mem [0:262143];
  bit wr_seen [0:262143];
  int cnt = 0, lat = 4;
  bit rand_lat = 0, prev_done = 0;
  logic [17:0] log_a[$];
  bit log_w[$];
  logic [31:0] log_d[$];
  bit mv [2][64];
  logic [10:0] mt [2][64];
  bit ml [64];

  sram_cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_re_en(sram_re_en), .sram_we_en(sram_we_en), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [17:0] a);
    if (a == 18'h00084) return 32'hAAAA0001;
    if (a == 18'h00085) return 32'hBBBB0002;
    return {a, 14'h2A5} ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [17:0] a);
    return wr_seen[a] ? mem[a] : mem_init(a);
  endfunction

  always_comb sram_rdata = !sram_re_en ? 32'h0 : wr_seen[sram_address] ? mem[sram_address] : mem_init(sram_address);
  assign sram_ready = !(sram_re_en || sram_we_en) || (cnt >= lat - 1);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (prev_done) begin
      checks++;
      if (sram_re_en || sram_we_en) begin
        errors++;
        $display("FAIL sram_gap: request at %0h issued with no idle cycle", sram_address);
      end
    end
    prev_done <= (sram_re_en || sram_we_en) && sram_ready;
    if (sram_re_en || sram_we_en) begin
      cnt <= cnt + 1;
      if (sram_ready) begin
        log_a.push_back(sram_address);
        log_w.push_back(sram_we_en);
        log_d.push_back(sram_wdata);
        if (sram_we_en) begin
          mem[sram_address] <= sram_wdata;
          wr_seen[sram_address] <= 1'b1;
        end
      end
    end else begin
      cnt <= 0;
      lat <= rand_lat ? int'($urandom_range(1, 4)) : 4;
    end
  end

  always @(negedge clk) begin
    if (!rst && ready && rd_en && !wr_en) begin
      checks++;
      if (rdata !== mem_rd(addr)) begin
        errors++;
        $display("FAIL rdata @%0h: got %0h expected %0h", addr, rdata, mem_rd(addr));
      end
    end
  end

  function automatic void model_clear();
    for (int s = 0; s < 64; s++) begin
      mv[0][s] = 0;
      mv[1][s] = 0;
      ml[s] = 0;
    end
  endfunction

  function automatic void mlookup(input logic [17:0] a, output bit h, output int way);
    int s = int'(a[6:1]);
    h = 0;
    way = 0;
    for (int k = 0; k < 2; k++)
      if (mv[k][s] && mt[k][s] == a[17:7]) begin
        h = 1;
        way = k;
      end
  endfunction

  function automatic void install(input logic [17:0] a);
    int s = int'(a[6:1]);
    int v = !mv[0][s] ? 0 : !mv[1][s] ? 1 : int'(ml[s]);
    mv[v][s] = 1;
    mt[v][s] = a[17:7];
    ml[s] = (v == 0);
  endfunction

  task automatic do_op(input bit r, input bit w, input logic [17:0] a, input logic [31:0] d,
                       input int exp_hit, output logic [31:0] got);
    bit mh;
    int way, cyc;
    mlookup(a, mh, way);
    @(posedge clk);
    #1;
    rd_en = r;
    wr_en = w;
    addr = a;
    wdata = d;
    log_a.delete();
    log_w.delete();
    log_d.delete();
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      cyc++;
      if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: ready still %0b after %0d cycles at %0h", ready, cyc, a);
        break;
      end
    end
    got = rdata;
    if (w) begin
      chk("wr_stall", cyc > 0, 1);
      chk("wr_req_count", log_a.size(), 1);
      if (log_a.size() == 1) begin
        chk("wr_addr", log_a[0], a);
        chk("wr_is_write", log_w[0], 1);
        chk("wr_data", log_d[0], d);
      end
    end else if (r) begin
      if (exp_hit >= 0) chk("model_hit", mh, exp_hit[0]);
      if (mh) begin
        chk("hit_latency", cyc, 0);
        chk("hit_req_count", log_a.size(), 0);
        ml[a[6:1]] = (way == 0);
      end else begin
        chk("miss_req_count", log_a.size(), 2);
        if (log_a.size() == 2) begin
          chk("fill0_addr", log_a[0], {a[17:1], 1'b0});
          chk("fill1_addr", log_a[1], {a[17:1], 1'b1});
          chk("fill_is_read", {log_w[0], log_w[1]}, 0);
        end
        install(a);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rd_en = 0;
      wr_en = 0;
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [10:0] tg [4] = '{11'h000, 11'h001, 11'h7FF, 11'h2A5};
    logic [5:0] ix [3] = '{6'd4, 6'd9, 6'd33};
    int n;
    rst = 1;
    rd_en = 0;
    wr_en = 0;
    addr = 0;
    wdata = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_enables", {sram_re_en, sram_we_en}, 0);
    chk("rst_sram_address", sram_address, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    rst = 0;
    do_op(1, 0, 18'h00084, 0, 0, got);
    chk("cold_rdata", got, 32'hAAAA0001);
    do_op(1, 0, 18'h00085, 0, 1, got);
    chk("hit_rdata", got, 32'hBBBB0002);
    do_op(1, 0, 18'h00084, 0, 1, got);
    do_op(1, 0, 18'h10084, 0, 0, got);
    do_op(1, 0, 18'h00084, 0, 1, got);
    do_op(1, 0, 18'h20084, 0, 0, got);
    do_op(1, 0, 18'h10084, 0, 0, got);
    do_op(1, 0, 18'h00084, 0, 0, got);
    do_op(0, 1, 18'h00084, 32'hDEADBEEF, -1, got);
    do_op(1, 0, 18'h00084, 0, 1, got);
    chk("write_hit_rdata", got, 32'hDEADBEEF);
    do_op(0, 1, 18'h3FF00, 32'h12345678, -1, got);
    do_op(1, 0, 18'h3FF00, 0, 0, got);
    chk("write_miss_fill", got, 32'h12345678);
    do_op(1, 1, 18'h00010, 32'hCAFEF00D, -1, got);
    do_op(1, 0, 18'h00010, 0, 0, got);
    chk("both_high_rdata", got, 32'hCAFEF00D);
    idle(1);
    rd_en = 1;
    addr = 18'h00284;
    log_a.delete();
    n = 0;
    repeat (2) @(negedge clk);
    rd_en = 0;
    while (log_a.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("withdraw_fill_reqs", log_a.size(), 2);
    install(18'h00284);
    idle(3);
    do_op(1, 0, 18'h00285, 0, 1, got);
    idle(1);
    rd_en = 1;
    addr = 18'h00384;
    log_a.delete();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(log_a.size() == 1 && sram_re_en) && n < 100);
    chk("reached_fill1", log_a.size() == 1 && sram_re_en, 1);
    rst = 1;
    rd_en = 0;
    @(negedge clk);
    chk("midrst_enables", {sram_re_en, sram_we_en}, 0);
    chk("midrst_ready", ready, 1);
    rst = 0;
    model_clear();
    do_op(1, 0, 18'h00084, 0, 0, got);
    do_op(1, 0, 18'h00384, 0, 0, got);
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      logic [17:0] a;
      int op;
      a = {tg[$urandom_range(0, 3)], ix[$urandom_range(0, 2)], 1'($urandom_range(0, 1))};
      op = $urandom_range(0, 19);
      if (op < 12) do_op(1, 0, a, 0, -1, got);
      else if (op < 17) do_op(0, 1, a, $urandom, -1, got);
      else do_op(1, 1, a, $urandom, -1, got);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_cache_controller.md
Name: sram_cache_controller

Overview:
- Sits between the MEM stage and the SRAM controller, on the MEM-stage side of the SRAM controller.
- 2-way set-associative read cache: 64 sets, 2-word (64-bit) lines, one LRU bit per set.
- Write-through, no-write-allocate.
- Drives the SRAM controller's request/ready handshake and stalls the pipeline through `ready`.

Parameters:
- SETS, 64, number of sets (power of 2); index width IDX = log2(SETS) = 6.
- TAG_W, 11, tag width = 18 - IDX - 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rd_en  in  1  MEM-stage load request
- wr_en  in  1  MEM-stage store request
- addr  in  18  word address from MEM stage; [0]=word-in-line, [6:1]=index, [17:7]=tag
- wdata  in  32  store data
- rdata  out  32  load data, valid when ready=1 and rd_en=1
- ready  out  1  0 = stall pipeline
- sram_address  out  18  word address to SRAM controller
- sram_wdata  out  32  store data to SRAM controller
- sram_re_en  out  1  SRAM read request
- sram_we_en  out  1  SRAM write request
- sram_rdata  in  32  SRAM controller read data
- sram_ready  in  1  SRAM controller ready; high when idle, low while a request is in progress

Behaviour:
- Reset: all valid bits=0, LRU=0, FSM=IDLE, sram_re_en=sram_we_en=0, sram_address=0, sram_wdata=0, rdata=0, ready=1.
- Priority: wr_en wins if rd_en and wr_en are both high.
- Hit: valid[way][idx] and tag[way][idx]==addr[17:7].
- LRU[idx] names the victim way. It is set to the other way on every read hit and every fill.

States: IDLE, FILL0, GAP, FILL1, WRITE, DONE.

- IDLE, read hit:
  - rdata=line[way][addr[0]] combinationally; ready=1 the same cycle (zero-latency).
  - Update LRU at the clock edge.
- IDLE, read miss:
  - ready=0.
  - Go to FILL0 with sram_re_en=1, sram_address={addr[17:1],1'b0}.
- FILL0:
  - Hold the request until sram_ready=1 is sampled with sram_re_en=1.
  - Latch sram_rdata as word0.
  - Drop sram_re_en and go to GAP.
- GAP:
  - One cycle with both enables low. This is mandatory between SRAM requests because the SRAM controller's cycle counter clears only on idle.
  - Then go to FILL1 with sram_address={addr[17:1],1'b1}, sram_re_en=1.
- FILL1:
  - On sram_ready=1, write {sram_rdata, word0} into the victim way, set valid, write tag, flip LRU.
  - Go to DONE.
- DONE:
  - ready=1 for exactly one cycle; rdata = the filled word selected by addr[0].
  - Return to IDLE. Enables are already low, which guarantees the SRAM gap.
- IDLE, wr_en:
  - ready=0; go to WRITE with sram_we_en=1, sram_address=addr, sram_wdata=wdata.
  - On a hit, update the matching word of the hit way at entry. LRU is unchanged.
  - On a miss, cache contents are unchanged.
- WRITE:
  - Hold until sram_ready=1 is sampled with sram_we_en=1.
  - Deassert and go to DONE.
- Stall contract:
  - ready=0 in every state except IDLE-hit and DONE.
  - The MEM stage holds addr/wdata/rd_en/wr_en stable while ready=0.
  - The block latches addr and wdata on leaving IDLE and uses only the latched copies afterwards.
- Request withdrawn mid-operation (rd_en/wr_en dropped while not IDLE): the block completes the SRAM transaction anyway. An abandoned fill still installs the line.
- Reset mid-operation:
  - Any state returns to IDLE next cycle; enables drop and all lines are invalidated.
  - A partially written line is never marked valid.
- Both ways valid on a miss: replace the LRU way. One way invalid: replace the invalid way, way0 first.
- Read miss latency = 2 × SRAM transaction + GAP + DONE (≥ 10 cycles with a 4-cycle SRAM controller).

Decomposition:
- Shared package:
  - state enum (IDLE, FILL0, GAP, FILL1, WRITE, DONE)
  - constants SETS, IDX, TAG_W
  - address field slice positions
- One sub-module, cache_way_array: two ways of {valid, tag, 64-bit data} plus the LRU array.
  - Combinational hit/way/data lookup.
  - Synchronous fill, word-write and invalidate ports.
- The FSM and handshake logic stay in the top.

Test Plan:
- Cold read addr=0x00084 with SRAM returning 0xAAAA0001 / 0xBBBB0002 for words 0x00084 / 0x00085:
  - sram_re_en issued twice, for addresses 0x00084 then 0x00085, with one idle cycle between requests.
  - ready=1 in DONE with rdata=0xAAAA0001.
  - An immediate read of 0x00085 is a hit in the same cycle with rdata=0xBBBB0002.
- Read 0x00084 (way0), then 0x10084 (same index; way1), then re-read 0x00084 (hit), then read 0x20084 → the 0x10084 line is evicted; re-reading 0x10084 misses.
- Write wdata=0xDEADBEEF to cached 0x00084:
  - sram_we_en held until sram_ready, ready=0 throughout.
  - A subsequent read of 0x00084 hits with 0xDEADBEEF and issues no SRAM request.
- Write to uncached 0x3FF00: one SRAM write; a following read of 0x3FF00 misses and fills from SRAM.
- rd_en and wr_en both high at 0x00010: only a write transaction is issued and no fill occurs.
- Assert rst during FILL1: next cycle enables=0, ready=1, state IDLE; a read of the earlier-cached 0x00084 misses.
